// File: rtl/nes_linebuf_pkg.sv
// Scanline line-buffer definitions shared by the PPU pixel writer, the VGA scan-out
// reader and the port arbiter that sits between them.
package nes_linebuf_pkg;

    localparam int LB_X_W     = 8;
    localparam int LB_ADDR_W  = 9;
    localparam int LB_DATA_W  = 15;
    localparam int LB_ENTRY_W = 1 + LB_X_W + LB_DATA_W;

    // Packed layout: bank in the MSB, then the pixel column, then BGR555 colour in the LSBs.
    typedef struct packed {
        logic                 bank;
        logic [LB_X_W-1:0]    x;
        logic [LB_DATA_W-1:0] data;
    } lb_entry_t;

    function automatic logic [LB_ADDR_W-1:0] lb_entry_addr(input lb_entry_t e);
        return {e.bank, e.x};
    endfunction

endpackage

// File: rtl/linebuf_wfifo.sv
// Small synchronous FIFO holding pending PPU pixel writes; storage is plain registers
// and the head entry is visible combinationally.
module linebuf_wfifo
    import nes_linebuf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  lb_entry_t                   push_entry,
    input  logic                        pop,
    output lb_entry_t                   head,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

    logic [LB_ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == DEPTH_L);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = lb_entry_t'(mem[rd_ptr]);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/linebuf_port_arbiter.sv
// Shares the single-port scanline RAM between VGA reads (absolute priority) and
// buffered PPU writes, with sticky starvation and bank-collision flags.
module linebuf_port_arbiter
    import nes_linebuf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_valid,
    input  logic                 wr_bank,
    input  logic [LB_X_W-1:0]    wr_x,
    input  logic [LB_DATA_W-1:0] wr_data,
    output logic                 wr_ready,
    input  logic                 rd_req,
    input  logic [LB_ADDR_W-1:0] rd_addr,
    output logic                 rd_valid,
    output logic [LB_DATA_W-1:0] rd_data,
    output logic                 ram_we,
    output logic [LB_ADDR_W-1:0] ram_addr,
    output logic [LB_DATA_W-1:0] ram_wdata,
    input  logic [LB_DATA_W-1:0] ram_rdata,
    output logic                 err_starve,
    output logic                 err_collision
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    lb_entry_t            wr_entry;
    lb_entry_t            head;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic [LB_ADDR_W-1:0] ram_addr_q;
    logic                 rd_req_p1;
    logic [3:0]           starve_cnt;
    logic [3:0]           starve_cnt_nxt;

    assign wr_entry = '{bank: wr_bank, x: wr_x, data: wr_data};
    assign wr_ready = (fifo_count != CNT_W'(FIFO_DEPTH));
    assign push     = wr_valid && !fifo_full;
    assign pop      = !reset && !rd_req && !fifo_empty;

    linebuf_wfifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (wr_entry),
        .pop        (pop),
        .head       (head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Port mux: reads win; writes fill free slots; an idle port parks on its last address.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ram_addr_q;
        ram_wdata = '0;
        if (reset) begin
            ram_addr = '0;
        end else if (rd_req) begin
            ram_addr = rd_addr;
        end else if (!fifo_empty) begin
            ram_we    = 1'b1;
            ram_addr  = lb_entry_addr(head);
            ram_wdata = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) ram_addr_q <= '0;
        else       ram_addr_q <= ram_addr;
    end

    // p1: RAM presents read data one cycle after the address; p2: registered return.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_req_p1 <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_req_p1 <= rd_req;
            rd_valid  <= rd_req_p1;
            if (rd_req_p1) rd_data <= ram_rdata;
        end
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (fifo_empty || pop) starve_cnt_nxt = 4'd0;
        else if (rd_req)       starve_cnt_nxt = sat_inc4(starve_cnt);
    end

    // The starve flag rises on the edge where the count reaches the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt    <= 4'd0;
            err_starve    <= 1'b0;
            err_collision <= 1'b0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
            if (int'(starve_cnt_nxt) >= STARVE_MAX) err_starve <= 1'b1;
            if (rd_req && !fifo_empty && (head.bank == rd_addr[LB_ADDR_W-1])) err_collision <= 1'b1;
        end
    end

endmodule

// File: tb/tb_linebuf_port_arbiter.sv
// Scoreboard bench for the line-buffer arbiter: the sequence queues expected RAM writes,
// read returns and point probes; a negedge monitor pops and compares them.
module tb_linebuf_port_arbiter;

    localparam int S_READY = 0, S_STARVE = 1, S_COLL = 2, S_WE = 3, S_ADDR = 4;
    localparam int S_WDATA = 5, S_RVALID = 6, S_RDATA = 7, S_WRQ = 8, S_RDQ = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_valid;
    logic        wr_bank;
    logic [7:0]  wr_x;
    logic [14:0] wr_data;
    logic        wr_ready;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_valid;
    logic [14:0] rd_data;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [14:0] ram_wdata;
    logic [14:0] ram_rdata;
    logic        err_starve;
    logic        err_collision;

    always #5 clk = ~clk;

    linebuf_port_arbiter #(
        .FIFO_DEPTH (4),
        .STARVE_MAX (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid      (wr_valid),
        .wr_bank       (wr_bank),
        .wr_x          (wr_x),
        .wr_data       (wr_data),
        .wr_ready      (wr_ready),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .err_starve    (err_starve),
        .err_collision (err_collision)
    );

    function automatic logic [14:0] pat(input logic [8:0] a);
        return (15'(a) * 15'd37) ^ 15'h2A5;
    endfunction

    // RAM model: synchronous read, one-cycle latency, preloaded with a known pattern.
    logic [14:0] mem [512];
    int          cyc = 0;

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 512; i++) mem[i] <= pat(9'(i));
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
        cyc       <= cyc + 1;
    end

    logic [23:0] exp_w  [1024];
    logic [14:0] exp_r  [1024];
    int          exp_rc [1024];
    int          ew_w = 0, ew_r = 0, er_w = 0, er_r = 0;

    string p_name [8];
    int    p_sel  [8];
    int    p_exp  [8];
    int    p_n = 0, p_seq = 0, p_done = 0;

    int n_checks = 0;
    int n_fails  = 0;

    function automatic int sample(input int sel);
        case (sel)
            S_READY:  return int'(wr_ready);
            S_STARVE: return int'(err_starve);
            S_COLL:   return int'(err_collision);
            S_WE:     return int'(ram_we);
            S_ADDR:   return int'(ram_addr);
            S_WDATA:  return int'(ram_wdata);
            S_RVALID: return int'(rd_valid);
            S_RDATA:  return int'(rd_data);
            S_WRQ:    return ew_w - ew_r;
            S_RDQ:    return er_w - er_r;
            default:  return -1;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (ram_we === 1'b1) begin
            n_checks++;
            if (ew_r >= ew_w) begin
                n_fails++;
                $display("FAIL ram_write: got addr=%h data=%h, required no write (cycle %0d)", ram_addr, ram_wdata, cyc);
            end else begin
                if ({ram_addr, ram_wdata} !== exp_w[ew_r]) begin
                    n_fails++;
                    $display("FAIL ram_write #%0d: got addr=%h data=%h, required addr=%h data=%h", ew_r,
                             ram_addr, ram_wdata, exp_w[ew_r][23:15], exp_w[ew_r][14:0]);
                end
                ew_r++;
            end
        end
        if (rd_valid === 1'b1) begin
            n_checks++;
            if (er_r >= er_w) begin
                n_fails++;
                $display("FAIL rd_return: got rd_valid data=%h, required none (cycle %0d)", rd_data, cyc);
            end else begin
                if (rd_data !== exp_r[er_r] || cyc != exp_rc[er_r]) begin
                    n_fails++;
                    $display("FAIL rd_return #%0d: got data=%h at cycle %0d, required data=%h at cycle %0d",
                             er_r, rd_data, cyc, exp_r[er_r], exp_rc[er_r]);
                end
                er_r++;
            end
        end
        if (p_seq != p_done) begin
            for (int i = 0; i < p_n; i++) begin
                int act;
                act = sample(p_sel[i]);
                n_checks++;
                if (act != p_exp[i]) begin
                    n_fails++;
                    $display("FAIL %s: got %0d, required %0d (cycle %0d)", p_name[i], act, p_exp[i], cyc);
                end
            end
            p_done = p_seq;
        end
    end

    task automatic chk(input string n, input int sel, input int e);
        p_name[p_n] = n;
        p_sel[p_n]  = sel;
        p_exp[p_n]  = e;
        p_n++;
    endtask

    task automatic step();
        p_seq++;
        @(negedge clk);
        #1;
        p_n = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic exp_read(input logic [8:0] a);
        exp_r[er_w]  = pat(a);
        exp_rc[er_w] = cyc + 2;
        er_w++;
    endtask

    task automatic drive_wr(input logic b, input logic [7:0] x, input logic [14:0] d, input bit expect_it);
        wr_valid = 1'b1;
        wr_bank  = b;
        wr_x     = x;
        wr_data  = d;
        if (expect_it) begin
            exp_w[ew_w] = {b, x, d};
            ew_w++;
        end
    endtask

    task automatic idle_inputs();
        wr_valid = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        step();
        reset = 1'b0;
        chk("rst_wr_ready", S_READY, 1);
        chk("rst_ram_we", S_WE, 0);
        chk("rst_ram_addr", S_ADDR, 0);
        chk("rst_ram_wdata", S_WDATA, 0);
        chk("rst_rd_valid", S_RVALID, 0);
        chk("rst_rd_data", S_RDATA, 0);
        chk("rst_err_starve", S_STARVE, 0);
        chk("rst_err_collision", S_COLL, 0);
        step();
    endtask

    task automatic drain_check(input string tag);
        chk({tag, "_wr_drain"}, S_WRQ, 0);
        chk({tag, "_rd_drain"}, S_RDQ, 0);
        step();
    endtask

    initial begin
        int  rdx, wrx, t, issued;
        bit  pend, acc;
        reset   = 1'b1;
        wr_bank = 1'b0;
        wr_x    = '0;
        wr_data = '0;
        rd_addr = '0;
        idle_inputs();

        // Single write into an empty FIFO.
        do_reset();
        drive_wr(1'b0, 8'd5, 15'h7FFF, 1'b1);
        chk("t1_no_fallthrough", S_WE, 0);
        step();
        wr_valid = 1'b0;
        chk("t1_we", S_WE, 1);
        chk("t1_addr", S_ADDR, 9'h005);
        chk("t1_wdata", S_WDATA, 15'h7FFF);
        step();
        chk("t1_empty_after", S_WE, 0);
        step();
        drain_check("t1");

        // Even-cycle reads of bank 1 while bank-0 pixels arrive every third cycle.
        do_reset();
        rdx = 0; wrx = 0; t = 0; pend = 1'b0;
        while ((rdx < 256 || wrx < 256) && t < 3000) begin
            rd_req  = (t % 2 == 0) && (rdx < 256);
            rd_addr = {1'b1, 8'(rdx)};
            if (rd_req) begin
                exp_read(rd_addr);
                rdx++;
            end
            if (!pend && wrx < 256 && t % 3 == 0) begin
                pend = 1'b1;
                drive_wr(1'b0, 8'(wrx), 15'(wrx * 129 + 7), 1'b1);
            end
            wr_valid = pend;
            acc = pend && wr_ready;
            step();
            if (acc) begin
                pend = 1'b0;
                wrx++;
            end
            t++;
        end
        idle_inputs();
        repeat (8) step();
        chk("t2_starve", S_STARVE, 0);
        chk("t2_collision", S_COLL, 0);
        step();
        drain_check("t2");

        // Reads hold the port: FIFO fills, write slot starves, then drains in order.
        do_reset();
        issued = 0; pend = 1'b0;
        for (int k = 0; k < 24; k++) begin
            rd_req  = (k < 12);
            rd_addr = 9'h1A0;
            if (rd_req) exp_read(rd_addr);
            if (!pend && issued < 5) begin
                pend = 1'b1;
                drive_wr(1'b0, 8'(10 + issued), 15'(16'h1000 + issued), 1'b1);
            end
            wr_valid = pend;
            if (k == 3)  chk("t3_ready_before_full", S_READY, 1);
            if (k == 4)  chk("t3_full_ready", S_READY, 0);
            if (k == 8)  chk("t3_starve_early", S_STARVE, 0);
            if (k == 9)  chk("t3_starve_set", S_STARVE, 1);
            if (k == 11) chk("t3_no_write_while_read", S_WE, 0);
            if (k == 12) chk("t3_release_we", S_WE, 1);
            acc = pend && wr_ready;
            step();
            if (acc) begin
                pend = 1'b0;
                issued++;
            end
        end
        idle_inputs();
        chk("t3_starve_sticky", S_STARVE, 1);
        chk("t3_collision", S_COLL, 0);
        step();
        drain_check("t3");

        // Read of bank 1 while the FIFO head targets bank 1.
        do_reset();
        drive_wr(1'b1, 8'd3, 15'h0ABC, 1'b1);
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        rd_addr  = 9'h100;
        exp_read(rd_addr);
        chk("t4_coll_not_yet", S_COLL, 0);
        step();
        rd_req = 1'b0;
        chk("t4_coll_set", S_COLL, 1);
        chk("t4_write_after", S_WE, 1);
        step();
        repeat (6) begin
            chk("t4_coll_sticky", S_COLL, 1);
            step();
        end
        drain_check("t4");

        // Push and pop together at count 2 across several pointer wraps.
        do_reset();
        for (int k = 0; k < 16; k++) begin
            rd_req  = (k < 2);
            rd_addr = 9'h1C0;
            if (rd_req) exp_read(rd_addr);
            if (k < 12) drive_wr(1'b0, 8'(100 + k), 15'(16'h2000 + k), 1'b1);
            else        wr_valid = 1'b0;
            chk("t5_we", S_WE, (k >= 2 && k < 14) ? 1 : 0);
            if (k >= 2 && k < 12) chk("t5_ready", S_READY, 1);
            step();
        end
        idle_inputs();
        step();
        drain_check("t5");

        // Reset one cycle after a read, with three writes still queued.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rd_req  = 1'b1;
            rd_addr = 9'h1E0;
            if (k < 3) begin
                exp_read(rd_addr);
                drive_wr(1'b0, 8'(200 + k), 15'(16'h3000 + k), 1'b0);
            end else begin
                wr_valid = 1'b0;
            end
            step();
        end
        reset  = 1'b1;
        rd_req = 1'b0;
        chk("t6_we_in_reset", S_WE, 0);
        step();
        reset = 1'b0;
        chk("t6_rd_valid_dropped", S_RVALID, 0);
        chk("t6_ready_after", S_READY, 1);
        chk("t6_we_after", S_WE, 0);
        step();
        repeat (4) begin
            chk("t6_no_write", S_WE, 0);
            chk("t6_no_rd_valid", S_RVALID, 0);
            step();
        end
        drain_check("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
